mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Parametrised successor to the single-port request unit.
- Arbitrates the datapath's instruction-fetch and data load/store requests onto one shared memory-controller port.
- Generates byte-lane selects, extracts and sign-/zero-extends sub-word loads, and detects misaligned accesses.
- Aborts accesses the controller never acknowledges.
- Sits between the CPU datapath and the memory controller.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be 32 (byte/half/word sizing).
- TIMEOUT, 16, max cycles to wait for m_ready before abort; must be ≥2.

Ports:
- clk  in  1  system clock
- nRst  in  1  reset; one clock, asynchronous, active-low
- i_req  in  1  instruction fetch request, level, held until i_done
- i_addr  in  ADDR_W  fetch address; word aligned
- i_rdata  out  DATA_W  fetched instruction
- i_done  out  1  one-cycle fetch completion pulse
- d_ren  in  1  data load request, held until d_done
- d_wen  in  1  data store request, held until d_done
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data, right-justified
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_unsigned  in  1  zero-extend sub-word loads when 1
- d_rdata  out  DATA_W  extended load data
- d_done  out  1  one-cycle data completion pulse
- m_ren  out  1  memory read strobe
- m_wen  out  1  memory write strobe
- m_addr  out  ADDR_W  word-aligned memory address, low 2 bits forced 0
- m_wdata  out  DATA_W  store data shifted to its byte lane(s)
- m_sel  out  4  byte-lane enables
- m_rdata  in  DATA_W  memory read data
- m_ready  in  1  controller acknowledge, one cycle per access
- err  out  1  one-cycle pulse on misaligned, reserved-size, or timeout

Behaviour:
- Reset (async, nRst=0):
  - FSM returns to IDLE; wait counter cleared.
  - All outputs are 0, including i_rdata and d_rdata.
  - Reset mid-access drops the access with no done pulse.
- FSM states: IDLE, IACC, DACC, RESP.
- IDLE:
  - Data has priority: (d_ren|d_wen) → DACC; else i_req → IACC.
  - d_ren & d_wen together are treated as a store.
  - Misaligned data access or d_size=11 → no memory access. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - In that case err and d_done pulse next cycle, d_rdata=0, FSM stays IDLE.
  - i_addr[1:0]≠0 → err and i_done pulse, i_rdata=0.
- Memory-side outputs are registered:
  - A request sampled in IDLE at edge N drives m_ren/m_wen, m_addr, m_sel, m_wdata from N+1.
  - These hold steady until acknowledge or abort.
- m_sel:
  - byte: 1<<addr[1:0]
  - half: 0011 or 1100 per addr[1]
  - word: 1111
  - Fetch and load also drive m_sel per size (fetch always 1111).
- m_wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- In IACC/DACC, m_ready sampled 1 at edge M:
  - Strobes drop at M+1.
  - Data is captured and the done pulse is asserted at M+1.
  - FSM moves to RESP.
- RESP:
  - Lasts one cycle; done pulse is high here.
  - Next request can be sampled at the end of RESP, so the next strobe rises at M+2.
  - A requester still holding its request in RESP is not re-granted in the same cycle.
- Load extraction:
  - Select lane per addr[1:0]/size.
  - Sign-extend from bit 7/15 unless d_unsigned=1.
- i_rdata/d_rdata hold their last value until the next completion for that channel.
- Timeout:
  - Counter increments each cycle in IACC/DACC without m_ready.
  - At count TIMEOUT, drop strobes and go to RESP with done=1, err=1, rdata=0.
  - A write is considered not performed.
- m_ready outside IACC/DACC is ignored.
- Requests deasserted mid-access are ignored: the access completes and done still pulses.
- Starvation: after a data access completes, if i_req is pending the next grant goes to fetch, even if data is also pending. This alternation guarantees fetch progress.

Test Plan:
- Fetch: i_req=1, i_addr=0x100, m_ready high 2 cycles after m_ren, m_rdata=0x00A00093 -> m_ren rises at N+1, i_done pulses once, i_rdata=0x00A00093, m_sel=1111.
- Signed byte load: d_ren, d_addr=0x203, d_size=00, d_unsigned=0, m_rdata=0x80FFFFFF -> m_sel=1000, m_addr=0x200, d_rdata=0xFFFFFF80; same with d_unsigned=1 -> 0x00000080.
- Half store: d_wen, d_addr=0x302, d_size=01, d_wdata=0x0000BEEF -> m_wen=1, m_sel=1100, m_wdata=0xBEEFBEEF, d_done one cycle after m_ready.
- Simultaneous i_req and d_ren in IDLE -> data granted first; fetch granted next even with d_ren reasserted; the two done pulses alternate.
- Misaligned word load at 0x101 -> no m_ren, err and d_done pulse next cycle, d_rdata=0. Timeout case: m_ready never asserts -> strobe held exactly TIMEOUT cycles, then err+done pulse.
- nRst low while m_wen active -> all outputs 0 immediately, no done pulse; after release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// Bundle between datapath, arbiter and memory controller.
// Fetch (i_*), data (d_*) and memory-side (m_*) signals plus err.
// slave: arbiter view. master: datapath/controller environment view.
// Signals:
//   i_req/i_addr/i_rdata/i_done            instruction fetch channel
//   d_ren/d_wen/d_addr/d_wdata/d_size      data load/store request
//   d_unsigned/d_rdata/d_done              data load result and completion
//   m_ren/m_wen/m_addr/m_wdata/m_sel       shared memory controller strobes
//   m_rdata/m_ready                        controller read data and ack
//   err                                    misalign / reserved / timeout pulse
`timescale 1ns/1ps
interface mem_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic              m_ren;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_sel;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    logic              err;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata,
        input  d_size, d_unsigned, m_rdata, m_ready,
        output i_rdata, i_done, d_rdata, d_done,
        output m_ren, m_wen, m_addr, m_wdata, m_sel, err
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata,
        output d_size, d_unsigned, m_rdata, m_ready,
        input  i_rdata, i_done, d_rdata, d_done,
        input  m_ren, m_wen, m_addr, m_wdata, m_sel, err
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// Shares one memory-controller port between fetch and data requests.
// Ports: clk, nRst (async active-low), bus (mem_request_arbiter_if.slave).
// Data wins in IDLE; a channel is masked while its done pulse is showing,
// so a completed data access hands the next grant to a pending fetch.
// All outputs are registered; accesses without m_ready abort after TIMEOUT.
`timescale 1ns/1ps
module mem_request_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                nRst,
    mem_request_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_m_ren;
    logic              r_m_wen;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [3:0]        r_m_sel;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_lo;
    logic              r_uns;

    logic              w_d_req;
    logic              w_i_req;
    logic              w_d_bad;
    logic              w_i_bad;
    logic              w_tmo;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;

    // The done pulse doubles as a one-cycle mask so a requester still
    // holding its line while it sees done is not granted again.
    assign w_d_req = (bus.d_ren | bus.d_wen) & ~r_d_done;
    assign w_i_req = bus.i_req & ~r_i_done;

    assign w_d_bad = (bus.d_size == 2'b11)
        | ((bus.d_size == 2'b01) & bus.d_addr[0])
        | ((bus.d_size == 2'b10) & (bus.d_addr[1:0] != 2'b00));
    assign w_i_bad = (bus.i_addr[1:0] != 2'b00);

    assign w_tmo = ~bus.m_ready & (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                w_sel   = 4'b0001 << bus.d_addr[1:0];
                w_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                w_sel   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus.m_rdata[{r_lo, 3'b000} +: 8];
        w_half = r_lo[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
        case (r_size)
            2'b00: w_load = r_uns ? {{(DATA_W-8){1'b0}}, w_byte}
                                  : {{(DATA_W-8){w_byte[7]}}, w_byte};
            2'b01: w_load = r_uns ? {{(DATA_W-16){1'b0}}, w_half}
                                  : {{(DATA_W-16){w_half[15]}}, w_half};
            default: w_load = bus.m_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_m_ren   <= 1'b0;
            r_m_wen   <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_sel   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            r_size    <= '0;
            r_lo      <= '0;
            r_uns     <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                IDLE, RESP: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    if (w_d_req) begin
                        if (w_d_bad) begin
                            r_d_done  <= 1'b1;
                            r_err     <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_state   <= DACC;
                            r_m_ren   <= ~bus.d_wen;
                            r_m_wen   <= bus.d_wen;
                            r_m_addr  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                            r_m_sel   <= w_sel;
                            r_m_wdata <= bus.d_wen ? w_wdata : '0;
                            r_size    <= bus.d_size;
                            r_lo      <= bus.d_addr[1:0];
                            r_uns     <= bus.d_unsigned;
                        end
                    end else if (w_i_req) begin
                        if (w_i_bad) begin
                            r_i_done  <= 1'b1;
                            r_err     <= 1'b1;
                            r_i_rdata <= '0;
                        end else begin
                            r_state   <= IACC;
                            r_m_ren   <= 1'b1;
                            r_m_addr  <= bus.i_addr;
                            r_m_sel   <= 4'b1111;
                            r_m_wdata <= '0;
                        end
                    end
                end
                IACC, DACC: begin
                    if (bus.m_ready || w_tmo) begin
                        r_state   <= RESP;
                        r_cnt     <= '0;
                        r_m_ren   <= 1'b0;
                        r_m_wen   <= 1'b0;
                        r_m_addr  <= '0;
                        r_m_sel   <= '0;
                        r_m_wdata <= '0;
                        r_err     <= w_tmo;
                        if (r_state == DACC) begin
                            r_d_done <= 1'b1;
                            if (w_tmo)
                                r_d_rdata <= '0;
                            else if (r_m_ren)
                                r_d_rdata <= w_load;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= w_tmo ? '0 : bus.m_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_ren   = r_m_ren;
    assign bus.m_wen   = r_m_wen;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_sel   = r_m_sel;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.i_done  = r_i_done;
    assign bus.d_done  = r_d_done;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mem_request_arbiter;
    localparam int TMO = 6;

    logic clk = 1'b0;
    logic nRst;
    int   checks   = 0;
    int   failures = 0;

    mem_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_request_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(negedge clk);
    endtask

    function automatic logic [136:0] all_out();
        return {bus.i_rdata, bus.i_done, bus.d_rdata, bus.d_done,
                bus.m_ren, bus.m_wen, bus.m_addr, bus.m_wdata,
                bus.m_sel, bus.err};
    endfunction

    task automatic idle_inputs();
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_ren      = 1'b0;
        bus.d_wen      = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_size     = 2'b00;
        bus.d_unsigned = 1'b0;
        bus.m_rdata    = '0;
        bus.m_ready    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRst = 1'b1;
        #1 nRst = 1'b0;
        nxt();
        nxt();
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_out());
        end
        nRst = 1'b1;
        nxt();
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", all_out());
        end
    endtask

    task automatic test_fetch();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        nxt();
        checks++;
        if (bus.m_ren !== 1'b1 || bus.m_wen !== 1'b0) begin
            failures++;
            $display("FAIL fetch_strobe got=%b%b exp=10", bus.m_ren, bus.m_wen);
        end
        checks++;
        if (bus.m_sel !== 4'b1111) begin
            failures++;
            $display("FAIL fetch_sel got=%b exp=1111", bus.m_sel);
        end
        checks++;
        if (bus.m_addr !== 32'h100) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=00000100", bus.m_addr);
        end
        nxt();
        checks++;
        if (bus.m_ren !== 1'b1 || bus.i_done !== 1'b0) begin
            failures++;
            $display("FAIL fetch_hold ren=%b done=%b exp=1,0", bus.m_ren, bus.i_done);
        end
        nxt();
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h00A00093;
        nxt();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.i_done !== 1'b1 || bus.m_ren !== 1'b0) begin
            failures++;
            $display("FAIL fetch_done done=%b ren=%b exp=1,0", bus.i_done, bus.m_ren);
        end
        checks++;
        if (bus.i_rdata !== 32'h00A00093) begin
            failures++;
            $display("FAIL fetch_rdata got=%h exp=00a00093", bus.i_rdata);
        end
        bus.i_req = 1'b0;
        nxt();
        checks++;
        if (bus.i_done !== 1'b0 || bus.m_ren !== 1'b0) begin
            failures++;
            $display("FAIL fetch_single_pulse done=%b ren=%b exp=0,0", bus.i_done, bus.m_ren);
        end
    endtask

    task automatic test_loads();
        logic [31:0] exp;
        for (int u = 0; u < 2; u++) begin
            bus.d_ren      = 1'b1;
            bus.d_addr     = 32'h203;
            bus.d_size     = 2'b00;
            bus.d_unsigned = (u == 1);
            nxt();
            checks++;
            if (bus.m_sel !== 4'b1000 || bus.m_addr !== 32'h200 || bus.m_ren !== 1'b1) begin
                failures++;
                $display("FAIL lb_request u=%0d sel=%b addr=%h ren=%b exp=1000,00000200,1",
                         u, bus.m_sel, bus.m_addr, bus.m_ren);
            end
            bus.m_ready = 1'b1;
            bus.m_rdata = 32'h80FFFFFF;
            nxt();
            bus.m_ready = 1'b0;
            bus.d_ren   = 1'b0;
            exp = (u == 1) ? 32'h00000080 : 32'hFFFFFF80;
            checks++;
            if (bus.d_done !== 1'b1 || bus.d_rdata !== exp) begin
                failures++;
                $display("FAIL lb_data u=%0d done=%b got=%h exp=%h", u, bus.d_done, bus.d_rdata, exp);
            end
            nxt();
        end
        bus.d_ren      = 1'b1;
        bus.d_addr     = 32'h202;
        bus.d_size     = 2'b01;
        bus.d_unsigned = 1'b0;
        nxt();
        checks++;
        if (bus.m_sel !== 4'b1100) begin
            failures++;
            $display("FAIL lh_sel got=%b exp=1100", bus.m_sel);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h80011234;
        nxt();
        bus.m_ready = 1'b0;
        bus.d_ren   = 1'b0;
        checks++;
        if (bus.d_rdata !== 32'hFFFF8001) begin
            failures++;
            $display("FAIL lh_data got=%h exp=ffff8001", bus.d_rdata);
        end
        nxt();
    endtask

    task automatic test_store();
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h302;
        bus.d_size  = 2'b01;
        bus.d_wdata = 32'h0000BEEF;
        nxt();
        checks++;
        if (bus.m_wen !== 1'b1 || bus.m_ren !== 1'b0 || bus.m_sel !== 4'b1100) begin
            failures++;
            $display("FAIL sh_request wen=%b ren=%b sel=%b exp=1,0,1100",
                     bus.m_wen, bus.m_ren, bus.m_sel);
        end
        checks++;
        if (bus.m_wdata !== 32'hBEEFBEEF || bus.m_addr !== 32'h300) begin
            failures++;
            $display("FAIL sh_data wdata=%h addr=%h exp=beefbeef,00000300", bus.m_wdata, bus.m_addr);
        end
        nxt();
        checks++;
        if (bus.d_done !== 1'b0 || bus.m_wen !== 1'b1) begin
            failures++;
            $display("FAIL sh_hold done=%b wen=%b exp=0,1", bus.d_done, bus.m_wen);
        end
        bus.m_ready = 1'b1;
        nxt();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.d_done !== 1'b1 || bus.m_wen !== 1'b0) begin
            failures++;
            $display("FAIL sh_done done=%b wen=%b exp=1,0", bus.d_done, bus.m_wen);
        end
        bus.d_wen = 1'b0;
        nxt();
        bus.d_ren   = 1'b1;
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h301;
        bus.d_size  = 2'b00;
        bus.d_wdata = 32'h12345677;
        nxt();
        checks++;
        if (bus.m_wen !== 1'b1 || bus.m_ren !== 1'b0 || bus.m_sel !== 4'b0010
            || bus.m_wdata !== 32'h77777777) begin
            failures++;
            $display("FAIL sb_rw_as_store wen=%b ren=%b sel=%b wdata=%h exp=1,0,0010,77777777",
                     bus.m_wen, bus.m_ren, bus.m_sel, bus.m_wdata);
        end
        bus.m_ready = 1'b1;
        nxt();
        bus.m_ready = 1'b0;
        bus.d_ren   = 1'b0;
        bus.d_wen   = 1'b0;
        nxt();
    endtask

    task automatic test_back_to_back();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h400;
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h500;
        bus.d_size = 2'b10;
        nxt();
        checks++;
        if (bus.m_addr !== 32'h500 || bus.m_ren !== 1'b1) begin
            failures++;
            $display("FAIL b2b_data_first addr=%h ren=%b exp=00000500,1", bus.m_addr, bus.m_ren);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h11111111;
        nxt();
        bus.m_ready = 1'b0;
        checks++;
        if (bus.d_done !== 1'b1 || bus.i_done !== 1'b0 || bus.d_rdata !== 32'h11111111) begin
            failures++;
            $display("FAIL b2b_d_done d=%b i=%b rdata=%h exp=1,0,11111111",
                     bus.d_done, bus.i_done, bus.d_rdata);
        end
        nxt();
        checks++;
        if (bus.m_addr !== 32'h400 || bus.m_ren !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fetch_next addr=%h ren=%b exp=00000400,1", bus.m_addr, bus.m_ren);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h22222222;
        nxt();
        bus.m_ready = 1'b0;
        bus.i_req   = 1'b0;
        checks++;
        if (bus.i_done !== 1'b1 || bus.d_done !== 1'b0 || bus.i_rdata !== 32'h22222222) begin
            failures++;
            $display("FAIL b2b_i_done i=%b d=%b rdata=%h exp=1,0,22222222",
                     bus.i_done, bus.d_done, bus.i_rdata);
        end
        nxt();
        checks++;
        if (bus.m_addr !== 32'h500 || bus.m_ren !== 1'b1) begin
            failures++;
            $display("FAIL b2b_data_again addr=%h ren=%b exp=00000500,1", bus.m_addr, bus.m_ren);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h33333333;
        nxt();
        bus.m_ready = 1'b0;
        bus.d_ren   = 1'b0;
        checks++;
        if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h33333333) begin
            failures++;
            $display("FAIL b2b_d_done2 d=%b rdata=%h exp=1,33333333", bus.d_done, bus.d_rdata);
        end
        nxt();
    endtask

    task automatic test_timeout();
        int strobe = 0;
        int pulses = 0;
        logic [31:0] dr = 32'hFFFFFFFF;
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h600;
        bus.d_size  = 2'b10;
        bus.d_wdata = 32'h00000055;
        for (int c = 0; c < 20; c++) begin
            nxt();
            if (bus.m_wen === 1'b1) strobe++;
            if (bus.d_done === 1'b1 && bus.err === 1'b1) begin
                pulses++;
                dr = bus.d_rdata;
                bus.d_wen = 1'b0;
            end
        end
        checks++;
        if (strobe != TMO) begin
            failures++;
            $display("FAIL tmo_strobe_cycles got=%0d exp=%0d", strobe, TMO);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL tmo_err_done_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (dr !== 32'h0) begin
            failures++;
            $display("FAIL tmo_rdata got=%h exp=00000000", dr);
        end
    endtask

    task automatic test_misaligned();
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h104;
        bus.d_size = 2'b10;
        nxt();
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h0BADF00D;
        nxt();
        bus.m_ready = 1'b0;
        bus.d_ren   = 1'b0;
        checks++;
        if (bus.d_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL lw_data got=%h exp=0badf00d", bus.d_rdata);
        end
        nxt();
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h101;
        bus.d_size = 2'b10;
        nxt();
        checks++;
        if (bus.m_ren !== 1'b0 || bus.err !== 1'b1 || bus.d_done !== 1'b1
            || bus.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mis_lw ren=%b err=%b done=%b rdata=%h exp=0,1,1,0",
                     bus.m_ren, bus.err, bus.d_done, bus.d_rdata);
        end
        bus.d_ren = 1'b0;
        nxt();
        checks++;
        if (bus.err !== 1'b0 || bus.d_done !== 1'b0 || bus.m_ren !== 1'b0) begin
            failures++;
            $display("FAIL mis_lw_pulse err=%b done=%b ren=%b exp=0,0,0",
                     bus.err, bus.d_done, bus.m_ren);
        end
        bus.d_ren  = 1'b1;
        bus.d_addr = 32'h100;
        bus.d_size = 2'b11;
        nxt();
        checks++;
        if (bus.err !== 1'b1 || bus.d_done !== 1'b1 || bus.m_ren !== 1'b0) begin
            failures++;
            $display("FAIL rsv_size err=%b done=%b ren=%b exp=1,1,0",
                     bus.err, bus.d_done, bus.m_ren);
        end
        bus.d_ren = 1'b0;
        nxt();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h102;
        nxt();
        checks++;
        if (bus.i_done !== 1'b1 || bus.err !== 1'b1 || bus.m_ren !== 1'b0
            || bus.i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mis_fetch done=%b err=%b ren=%b rdata=%h exp=1,1,0,0",
                     bus.i_done, bus.err, bus.m_ren, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        nxt();
    endtask

    task automatic test_reset_mid();
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h700;
        bus.d_size  = 2'b10;
        bus.d_wdata = 32'hCAFEF00D;
        nxt();
        checks++;
        if (bus.m_wen !== 1'b1 || bus.m_wdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL rst_mid_setup wen=%b wdata=%h exp=1,cafef00d", bus.m_wen, bus.m_wdata);
        end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=0", all_out());
        end
        bus.d_wen = 1'b0;
        nxt();
        nxt();
        nRst = 1'b1;
        nxt();
        checks++;
        if (bus.d_done !== 1'b0 || bus.m_wen !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_done done=%b wen=%b exp=0,0", bus.d_done, bus.m_wen);
        end
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h104;
        nxt();
        checks++;
        if (bus.m_ren !== 1'b1 || bus.m_addr !== 32'h104) begin
            failures++;
            $display("FAIL rst_fetch_req ren=%b addr=%h exp=1,00000104", bus.m_ren, bus.m_addr);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hDEADBEEF;
        nxt();
        bus.m_ready = 1'b0;
        bus.i_req   = 1'b0;
        checks++;
        if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.d_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_fetch_done i=%b rdata=%h d=%b exp=1,deadbeef,0",
                     bus.i_done, bus.i_rdata, bus.d_done);
        end
        nxt();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
